// File: rtl/el_pkg.sv
// Shared definitions for the el_fib sequencing controller: FSM states,
// dual-rail pair codes and the saturating term counter helper.
package el_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FRST,
      S_ARM,
      S_WDATA,
      S_WSPC,
      S_FIN,
      S_ERR
   } fib_state_e;

   typedef enum logic [1:0] {
      SPACER  = 2'b00,
      ZERO    = 2'b01,
      ONE     = 2'b10,
      ILLEGAL = 2'b11
   } rail_pair_e;

   localparam int unsigned IDX_W = 16;
   localparam logic [IDX_W-1:0] IDX_MAX = '1;

   function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
      return (v == IDX_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/el_fib_ctrl_if.sv
// Handshake bundle between the controller (master) and the dual-rail el_fib
// generator (slave); fib_data crosses in asynchronously.
interface el_fib_ctrl_if #(
   parameter int WIDTH = 32
);
   logic               fib_rst;
   logic               fib_start;
   logic               fib_ack;
   logic [2*WIDTH-1:0] fib_data;

   modport master (
      output fib_rst,
      output fib_start,
      output fib_ack,
      input  fib_data
   );

   modport slave (
      input  fib_rst,
      input  fib_start,
      input  fib_ack,
      output fib_data
   );
endinterface

// File: rtl/dr_decode.sv
// Purely combinational dual-rail decode of one synchronized codeword:
// per-pair completion, spacer detection, illegal detection and bit values.
module dr_decode
   import el_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] sd,
   output logic               complete_raw,
   output logic               empty,
   output logic               illegal,
   output logic [WIDTH-1:0]   value
);

   always_comb begin
      complete_raw = 1'b1;
      empty        = 1'b1;
      illegal      = 1'b0;
      value        = '0;
      for (int i = 0; i < WIDTH; i++) begin
         unique case (rail_pair_e'(sd[2*i +: 2]))
            SPACER: complete_raw = 1'b0;
            ZERO:   empty = 1'b0;
            ONE: begin
               empty    = 1'b0;
               value[i] = 1'b1;
            end
            ILLEGAL: begin
               complete_raw = 1'b0;
               empty        = 1'b0;
               illegal      = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/el_fib_ctrl.sv
// Sequences a dual-rail el_fib generator: resets it, starts it, and consumes
// 'count' terms through a four-phase ack handshake with timeout and error lock.
module el_fib_ctrl
   import el_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int RST_CYCLES = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 go,
   input  logic [15:0]          count,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [WIDTH-1:0]     result,
   output logic [15:0]          term_idx,
   el_fib_ctrl_if.master        fib
);

   localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

   logic [2*WIDTH-1:0] sync1_q;
   logic [2*WIDTH-1:0] sd_q;
   logic [2*WIDTH-1:0] sd_prev_q;

   logic             complete_raw;
   logic             empty;
   logic             illegal;
   logic             complete;
   logic [WIDTH-1:0] dec_value;

   fib_state_e       state_q,    state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [15:0]      count_q,    count_d;
   logic [WIDTH-1:0] result_q,   result_d;
   logic [15:0]      term_idx_q, term_idx_d;
   logic             busy_q,     busy_d;
   logic             done_q,     done_d;
   logic             err_q,      err_d;
   logic             fib_rst_q,  fib_rst_d;
   logic             fib_start_q, fib_start_d;
   logic             fib_ack_q,  fib_ack_d;

   // fib_data is asynchronous; sd_prev_q lets completion require one stable cycle
   // so a rail pair that lands late cannot produce a partial capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sd_q      <= '0;
         sd_prev_q <= '0;
      end else begin
         sync1_q   <= fib.fib_data;
         sd_q      <= sync1_q;
         sd_prev_q <= sd_q;
      end
   end

   dr_decode #(
      .WIDTH (WIDTH)
   ) u_decode (
      .sd           (sd_q),
      .complete_raw (complete_raw),
      .empty        (empty),
      .illegal      (illegal),
      .value        (dec_value)
   );

   assign complete = complete_raw && (sd_q == sd_prev_q);

   always_comb begin
      // NOTE: every _d starts from its _q so no path through this block infers a latch.
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      count_d    = count_q;
      result_d   = result_q;
      term_idx_d = term_idx_q;
      done_d     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (go) begin
               result_d   = '0;
               term_idx_d = '0;
               if (count == '0) begin
                  done_d = 1'b1;
               end else begin
                  count_d    = count;
                  wait_cnt_d = '0;
                  state_d    = S_FRST;
               end
            end
         end
         S_FRST: begin
            if (wait_cnt_q == RST_LAST) state_d = S_ARM;
            else                        wait_cnt_d = wait_cnt_q + 1'b1;
         end
         S_ARM: begin
            wait_cnt_d = '0;
            state_d    = S_WDATA;
         end
         S_WDATA: begin
            if (illegal) begin
               state_d = S_ERR;
            end else if (complete) begin
               result_d   = dec_value;
               term_idx_d = sat_inc(term_idx_q);
               wait_cnt_d = '0;
               state_d    = S_WSPC;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d = S_ERR;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         S_WSPC: begin
            if (illegal) begin
               state_d = S_ERR;
            end else if (empty) begin
               wait_cnt_d = '0;
               state_d    = (term_idx_q == count_q) ? S_FIN : S_WDATA;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d = S_ERR;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         S_FIN:   state_d = S_IDLE;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so the registered copies line
      // up with state_q in the same cycle.
      busy_d      = state_d inside {S_FRST, S_ARM, S_WDATA, S_WSPC, S_FIN};
      done_d      = done_d || (state_d == S_FIN);
      err_d       = (state_d == S_ERR);
      fib_rst_d   = state_d inside {S_IDLE, S_FRST, S_FIN, S_ERR};
      fib_start_d = state_d inside {S_ARM, S_WDATA, S_WSPC};
      fib_ack_d   = (state_d == S_WSPC);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wait_cnt_q  <= '0;
         count_q     <= '0;
         result_q    <= '0;
         term_idx_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         fib_rst_q   <= 1'b1;
         fib_start_q <= 1'b0;
         fib_ack_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         count_q     <= count_d;
         result_q    <= result_d;
         term_idx_q  <= term_idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         fib_rst_q   <= fib_rst_d;
         fib_start_q <= fib_start_d;
         fib_ack_q   <= fib_ack_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
   assign result        = result_q;
   assign term_idx      = term_idx_q;
   assign fib.fib_rst   = fib_rst_q;
   assign fib.fib_start = fib_start_q;
   assign fib.fib_ack   = fib_ack_q;

endmodule

// File: tb/tb_el_fib_ctrl.sv
// Self-checking bench for el_fib_ctrl: a behavioural dual-rail Fibonacci
// generator with optional per-pair skew, illegal-code and stuck-data modes.
module tb_el_fib_ctrl;

   localparam int WIDTH      = 32;
   localparam int RST_CYCLES = 4;
   localparam int TIMEOUT    = 16;
   localparam int M_NORMAL   = 0;
   localparam int M_ILLEGAL  = 1;
   localparam int M_HOLD     = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             go;
   logic [15:0]      count;
   logic             busy;
   logic             done;
   logic             err;
   logic [WIDTH-1:0] result;
   logic [15:0]      term_idx;

   el_fib_ctrl_if #(.WIDTH(WIDTH)) fib_if ();

   el_fib_ctrl #(
      .WIDTH      (WIDTH),
      .RST_CYCLES (RST_CYCLES),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .go       (go),
      .count    (count),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .result   (result),
      .term_idx (term_idx),
      .fib      (fib_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, want, $time);
      end
   endtask

   // k-th Fibonacci term of the 1, 1, 2, 3, 5 ... sequence, truncated to WIDTH.
   function automatic logic [WIDTH-1:0] fib_term(input int k);
      longint x = 1;
      longint y = 1;
      longint t;
      for (int i = 1; i < k; i++) begin
         t = x + y;
         x = y;
         y = t;
      end
      return x[WIDTH-1:0];
   endfunction

   // ---------------- behavioural el_fib generator ----------------
   int               mode    = M_NORMAL;
   bit               skew_en = 1'b0;
   int               phase;
   int               n_emit;
   logic [63:0]      fa, fb, ft;
   logic [2*WIDTH-1:0] tgt;
   int               dly [WIDTH];
   bit               arrived [WIDTH];

   task automatic arm_pairs();
      for (int i = 0; i < WIDTH; i++) begin
         dly[i]     = skew_en ? int'($urandom_range(0, 3)) : 0;
         arrived[i] = 1'b0;
      end
   endtask

   task automatic step_pairs(output bit all_in);
      all_in = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         if (!arrived[i]) begin
            if (dly[i] == 0) begin
               fib_if.fib_data[2*i +: 2] = tgt[2*i +: 2];
               arrived[i] = 1'b1;
            end else begin
               dly[i]--;
               all_in = 1'b0;
            end
         end
      end
   endtask

   initial begin
      bit all_in;
      fib_if.fib_data = '0;
      phase = 0; n_emit = 0; fa = 64'd1; fb = 64'd1; tgt = '0;
      forever begin
         @(posedge clk);
         #2;
         if (fib_if.fib_rst) begin
            fib_if.fib_data = '0;
            phase = 0; n_emit = 0; fa = 64'd1; fb = 64'd1;
         end else begin
            case (phase)
               0: begin
                  if (fib_if.fib_start && !fib_if.fib_ack) begin
                     n_emit++;
                     for (int i = 0; i < WIDTH; i++) tgt[2*i +: 2] = fa[i] ? 2'b10 : 2'b01;
                     if (mode == M_ILLEGAL && n_emit == 2) tgt[7:6] = 2'b11;
                     arm_pairs();
                     step_pairs(all_in);
                     phase = 1;
                  end
               end
               1: begin
                  step_pairs(all_in);
                  if (all_in && fib_if.fib_ack && mode != M_HOLD) begin
                     tgt = '0;
                     arm_pairs();
                     step_pairs(all_in);
                     ft = fa + fb; fa = fb; fb = ft;
                     phase = 2;
                  end
               end
               default: begin
                  step_pairs(all_in);
                  if (all_in) phase = 0;
               end
            endcase
         end
      end
   end

   // ---------------- per-cycle compare process ----------------
   int   ack_cnt     = 0;
   int   ack_total   = 0;
   int   done_total  = 0;
   int   start_rises = 0;
   logic prev_ack    = 1'b0;
   logic prev_busy   = 1'b0;
   logic prev_done   = 1'b0;
   logic prev_start  = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) ack_cnt = 0;
         else if (busy && !prev_busy) ack_cnt = 0;
         if (rst_n && fib_if.fib_ack && !prev_ack) begin
            ack_cnt++;
            ack_total++;
            check("result_on_ack", 64'(result), 64'(fib_term(ack_cnt)));
         end
         if (rst_n && busy) check("term_idx_track", 64'(term_idx), 64'(ack_cnt));
         if (done && !prev_done) done_total++;
         if (fib_if.fib_start && !prev_start) start_rises++;
         check("rst_start_excl", 64'(fib_if.fib_rst & fib_if.fib_start), 64'(0));
         if (err)
            check("err_outputs", 64'({fib_if.fib_rst, fib_if.fib_start, fib_if.fib_ack, busy}), 64'(4'b1000));
         else if (!busy)
            check("idle_outputs", 64'({fib_if.fib_rst, fib_if.fib_start, fib_if.fib_ack}), 64'(3'b100));
         if (fib_if.fib_ack) check("ack_while_busy", 64'(busy), 64'(1));
         if (prev_done) check("done_one_cycle", 64'(done), 64'(0));
         prev_ack   = fib_if.fib_ack;
         prev_busy  = busy;
         prev_done  = done;
         prev_start = fib_if.fib_start;
      end
   end

   // ---------------- scenario helpers ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_go(input logic [15:0] c);
      go    = 1'b1;
      count = c;
      tick();
      go    = 1'b0;
   endtask

   task automatic run_seq(input int c, input bit mid_go);
      int d0, a0, n;
      d0 = done_total;
      a0 = ack_total;
      pulse_go(16'(c));
      check("frst_entry", 64'({busy, fib_if.fib_rst, fib_if.fib_start}), 64'(3'b110));
      n = 0;
      while (!fib_if.fib_start && n < 50) begin
         tick();
         n++;
      end
      check("frst_len", 64'(n), 64'(RST_CYCLES));
      check("arm_rst_low", 64'(fib_if.fib_rst), 64'(0));
      if (mid_go) pulse_go(16'd1);
      n = 0;
      while (!done && n < 3000) begin
         tick();
         n++;
      end
      check("done_seen", 64'(done), 64'(1));
      check("busy_in_fin", 64'(busy), 64'(1));
      check("fin_rails", 64'({fib_if.fib_rst, fib_if.fib_start, fib_if.fib_ack}), 64'(3'b100));
      check("seq_result", 64'(result), 64'(fib_term(c)));
      check("seq_term_idx", 64'(term_idx), 64'(c));
      check("seq_acks", 64'(ack_total - a0), 64'(c));
      tick();
      check("busy_after_fin", 64'(busy), 64'(0));
      check("done_count", 64'(done_total - d0), 64'(1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no summary by %0t, want completion", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------- scenarios ----------------
   initial begin
      int  d0, s0, n, acks;
      bit  found;
      logic prev;

      rst_n = 1'b1; go = 1'b0; count = '0;
      #2 rst_n = 1'b0;
      repeat (3) tick();
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      check("rst_result", 64'(result), 64'(0));
      check("rst_term_idx", 64'(term_idx), 64'(0));
      check("rst_rails", 64'({fib_if.fib_rst, fib_if.fib_start, fib_if.fib_ack}), 64'(3'b100));
      rst_n = 1'b1;
      repeat (2) tick();

      // 1, 1, 2, 3, 5 without skew
      run_seq(5, 1'b0);
      check("fib5_result", 64'(result), 64'(5));
      check("fib5_term_idx", 64'(term_idx), 64'(5));

      // count = 0 completes immediately without touching el_fib
      s0 = start_rises;
      d0 = done_total;
      pulse_go(16'd0);
      check("cnt0_done", 64'(done), 64'(1));
      check("cnt0_result", 64'(result), 64'(0));
      check("cnt0_term_idx", 64'(term_idx), 64'(0));
      check("cnt0_busy", 64'(busy), 64'(0));
      repeat (10) tick();
      check("cnt0_no_start", 64'(start_rises - s0), 64'(0));
      check("cnt0_one_done", 64'(done_total - d0), 64'(1));

      // skewed rails, random lengths, go while busy ignored
      skew_en = 1'b1;
      for (int r = 0; r < 6; r++) run_seq(int'($urandom_range(1, 25)), r[0]);

      // illegal pair during the second term
      mode = M_ILLEGAL;
      d0 = done_total;
      pulse_go(16'd5);
      n = 0;
      while (!err && n < 2000) begin
         tick();
         n++;
      end
      check("illegal_err", 64'(err), 64'(1));
      check("illegal_rst", 64'(fib_if.fib_rst), 64'(1));
      check("illegal_result", 64'(result), 64'(1));
      check("illegal_term_idx", 64'(term_idx), 64'(1));
      pulse_go(16'd3);
      repeat (20) tick();
      check("err_sticky", 64'(err), 64'(1));
      check("err_go_ignored", 64'({busy, fib_if.fib_start}), 64'(0));
      check("err_no_done", 64'(done_total - d0), 64'(0));
      rst_n = 1'b0;
      tick();
      check("err_cleared", 64'(err), 64'(0));
      rst_n = 1'b1;
      tick();

      // data never returns to spacer: timeout measured from WSPC entry
      mode = M_HOLD;
      pulse_go(16'd3);
      n = 0;
      while (!fib_if.fib_ack && n < 500) begin
         tick();
         n++;
      end
      check("hold_ack_seen", 64'(fib_if.fib_ack), 64'(1));
      n = 0;
      while (!err && n < 100) begin
         tick();
         n++;
      end
      check("timeout_cycles", 64'(n), 64'(TIMEOUT));
      check("timeout_result", 64'(result), 64'(1));
      check("timeout_term_idx", 64'(term_idx), 64'(1));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      mode = M_NORMAL;
      tick();

      // asynchronous reset while waiting for the third term
      d0 = done_total;
      pulse_go(16'd5);
      acks = 0; prev = 1'b0; found = 1'b0;
      for (int k = 0; k < 3000 && !found; k++) begin
         tick();
         if (fib_if.fib_ack && !prev) acks++;
         if (acks == 2 && prev && !fib_if.fib_ack) found = 1'b1;
         prev = fib_if.fib_ack;
      end
      check("third_term_wait", 64'(found), 64'(1));
      check("third_term_idx", 64'(term_idx), 64'(2));
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_result", 64'(result), 64'(0));
      check("abort_term_idx", 64'(term_idx), 64'(0));
      check("abort_flags", 64'({done, err}), 64'(0));
      check("abort_rails", 64'({fib_if.fib_rst, fib_if.fib_start, fib_if.fib_ack}), 64'(3'b100));
      repeat (2) tick();
      check("abort_no_done", 64'(done_total - d0), 64'(0));
      rst_n = 1'b1;
      repeat (2) tick();
      run_seq(2, 1'b0);
      check("restart_result", 64'(result), 64'(1));
      check("restart_term_idx", 64'(term_idx), 64'(2));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/el_fib_ctrl.md
EL_FIB_CTRL -- requirements
Module: el_fib_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data width of the sequenced el_fib in bits.
REQ-002 SHALL have parameter RST_CYCLES, default 4, the number of cycles fib_rst is held high.
REQ-003 SHALL have parameter TIMEOUT, default 1024, the maximum number of cycles spent waiting in any handshake phase.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: go  in  1  one-cycle request to run a sequence; count  in  16  number of terms to consume, sampled on go.
REQ-006 SHALL have ports: busy  out  1  sequence in progress; done  out  1  one-cycle pulse on successful completion; err  out  1  sticky error flag.
REQ-007 SHALL have ports: result  out  WIDTH  last decoded term; term_idx  out  16  number of terms consumed so far.
REQ-008 SHALL have ports: fib_rst  out  1  active-high reset to el_fib; fib_start  out  1  el_fib start; fib_ack  out  1  el_fib ack_i.
REQ-009 SHALL have port fib_data  in  2*WIDTH  dual-rail el_fib output, asynchronous to clk.

Function
REQ-010 SHALL decode rail pair i as {fib_data[2i+1], fib_data[2i]}: 00 = spacer, 01 = bit value 0, 10 = bit value 1, 11 = illegal.
REQ-011 SHALL pass fib_data through a 2-flop synchronizer; all decode uses the second stage (sd).
REQ-012 SHALL treat a codeword as complete when every pair of sd is 01 or 10 and sd equals its value in the previous cycle; it is empty when every pair is 00.
REQ-013 SHALL implement the FSM IDLE -> FRST -> ARM -> WDATA -> WSPC -> (WDATA or FIN) -> IDLE, plus ERR.
REQ-014 In IDLE: busy=0; go with count=0 SHALL pulse done the next cycle, with result=0 and term_idx=0; go with count>0 SHALL latch count, clear term_idx, clear result, and enter FRST.
REQ-015 In FRST: fib_rst=1 and fib_start=0 for exactly RST_CYCLES cycles, then ARM.
REQ-016 In ARM: fib_rst=0 and fib_start=1; after one cycle, enter WDATA; fib_start stays 1 until FIN.
REQ-017 In WDATA: on the first complete codeword, load result with the decoded value, increment term_idx, set fib_ack=1 (registered, visible the next cycle), and enter WSPC.
REQ-018 In WSPC: on an empty codeword, drive fib_ack=0; if term_idx==latched count enter FIN, otherwise return to WDATA.
REQ-019 In FIN: drive fib_start=0 and fib_rst=1, pulse done for one cycle, then enter IDLE; fib_rst stays 1 while in IDLE.
REQ-020 Any illegal (11) pair in sd during WDATA or WSPC SHALL enter ERR.
REQ-021 A wait counter SHALL clear on every WDATA/WSPC entry; reaching TIMEOUT cycles in either state SHALL enter ERR.
REQ-022 In ERR: err=1, fib_rst=1, fib_start=0, fib_ack=0, busy=0; only reset clears ERR; go SHALL be ignored.
REQ-023 busy SHALL be 1 in FRST, ARM, WDATA, WSPC and FIN; go SHALL be ignored while busy=1.
REQ-024 term_idx SHALL saturate at 16'hFFFF; result SHALL be WIDTH bits with no extension.

Reset
REQ-025 rst_n low SHALL force, asynchronously: state=IDLE, fib_rst=1, fib_start=0, fib_ack=0, busy=0, done=0, err=0, result=0, term_idx=0, and both synchronizer stages=0.
REQ-026 Reset asserted mid-sequence SHALL abandon the sequence; no done pulse SHALL occur.

Structure
REQ-027 The FSM state encoding and the rail-pair codes (SPACER, ZERO, ONE, ILLEGAL) SHALL be defined in a shared package, el_pkg.
REQ-028 Dual-rail completion/decode SHALL live in one sub-module, dr_decode, a purely combinational block with outputs complete_raw, empty, illegal and value[WIDTH-1:0].

Verification
REQ-029 A behavioural el_fib model emits 1, 1, 2, 3, 5; count=5 -> five fib_ack rise/fall cycles, result=5, term_idx=5, one done pulse, and busy low the cycle after FIN.
REQ-030 count=0 -> done the cycle after go; fib_start never rises; result=0.
REQ-031 Model drives pair 3 = 11 during the second term -> err=1, fib_rst=1, result=1, term_idx=1, and go is ignored afterwards.
REQ-032 Model never returns to spacer after the first term, with TIMEOUT=16 -> ERR entered exactly 16 cycles after WSPC entry.
REQ-033 rst_n pulsed low during WDATA of the third term -> all outputs take their reset values immediately; a new go with count=2 completes normally.
REQ-034 Model skews rail arrival by 0-3 cycles per pair -> no partial value is ever captured, and results match the emitted sequence.
